// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// The segment table is active-high, with bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_DEAD = 1'b1
    } scan_state_t;

    // Digit counts outside 2..8 are clamped before the width is taken.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned c;
        if (n < 32'd2) begin
            c = 32'd2;
        end else if (n > 32'd8) begin
            c = 32'd8;
        end else begin
            c = n;
        end
        return $clog2(c);
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Three-stage sampler for an asynchronous level, with a one-cycle pulse on its
// rising edge. Also used to condition push-button inputs.
module sync_rise_detect #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s0_r;
    logic s1_r;
    logic s2_r;

    // Sampler shift chain; resetting to RESET_VAL suppresses a spurious edge at release.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_r <= RESET_VAL;
            s1_r <= RESET_VAL;
            s2_r <= RESET_VAL;
        end else begin
            s0_r <= din;
            s1_r <= s0_r;
            s2_r <= s1_r;
        end
    end

    assign rise = s1_r & ~s2_r;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: steps one digit per div_clk rising edge,
// with a one-cycle dark gap between digits and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic                    scan_tick
);

    localparam int unsigned IW = idx_width(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    // Pin-level "off" values; XOR with these converts active-high to pin polarity.
    localparam logic [NUM_DIGITS-1:0] AN_DARK  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_DARK = SEG_OFF ^ {7{ACTIVE_LOW}};

    logic                    tick_s;
    scan_state_t             state_r;
    scan_state_t             state_nxt_s;
    logic [IW-1:0]           idx_r;
    logic [IW-1:0]           idx_nxt_s;
    logic                    wrap_s;
    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [NUM_DIGITS-1:0]   en_r;
    logic                    blank_r;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic [NUM_DIGITS-1:0]   lit_s;
    logic [3:0]              nib_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;
    logic                    dp_out_r;
    logic [NUM_DIGITS-1:0]   an_nxt_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;

    sync_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .din   (div_clk),
        .rise  (tick_s)
    );

    // Next digit index, wrapping after the leftmost digit.
    always_comb begin
        if (idx_r == IDX_LAST) begin
            idx_nxt_s = {IW{1'b0}};
        end else begin
            idx_nxt_s = idx_r + IW'(1);
        end
    end

    assign wrap_s = tick_s && (idx_nxt_s == {IW{1'b0}});

    // Digit index advances once per scan tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r <= IDX_LAST;
        end else if (tick_s) begin
            idx_r <= idx_nxt_s;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Frame snapshot taken when the scan returns to digit 0, so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {(4*NUM_DIGITS){1'b0}};
            dp_r    <= {NUM_DIGITS{1'b0}};
            en_r    <= {NUM_DIGITS{1'b0}};
            blank_r <= 1'b0;
        end else if (wrap_s) begin
            value_r <= value;
            dp_r    <= dp;
            en_r    <= digit_en;
            blank_r <= blank_lz;
        end else begin
            value_r <= value_r;
            dp_r    <= dp_r;
            en_r    <= en_r;
            blank_r <= blank_r;
        end
    end

    // Leading-zero blanking: scan from the top digit while the run of zeros lasts.
    always_comb begin
        logic zero_run_s;
        zero_run_s = 1'b1;
        blank_s    = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (value_r[4*i +: 4] == 4'h0);
            if (blank_r && zero_run_s && (i != 0)) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    assign lit_s    = en_r & ~blank_s;
    assign nib_s    = value_r[{idx_r, 2'b00} +: 4];
    assign onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

    // Scan phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // A tick always opens a dead cycle, even if one is already in progress.
    always_comb begin
        state_nxt_s = ST_HOLD;
        case (state_r)
            ST_HOLD: begin
                if (tick_s) begin
                    state_nxt_s = ST_DEAD;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DEAD: begin
                if (tick_s) begin
                    state_nxt_s = ST_DEAD;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_HOLD;
        endcase
    end

    // Pin values: dark on a tick, new digit after the dead cycle, otherwise hold.
    always_comb begin
        an_nxt_s  = an_r;
        seg_nxt_s = seg_r;
        dp_nxt_s  = dp_out_r;
        if (tick_s) begin
            an_nxt_s  = AN_DARK;
            seg_nxt_s = SEG_DARK;
            dp_nxt_s  = ACTIVE_LOW;
        end else if (state_r == ST_DEAD) begin
            if (lit_s[idx_r]) begin
                an_nxt_s  = onehot_s ^ AN_DARK;
                seg_nxt_s = HEX_SEG[nib_s] ^ SEG_DARK;
                dp_nxt_s  = dp_r[idx_r] ^ ACTIVE_LOW;
            end else begin
                an_nxt_s  = AN_DARK;
                seg_nxt_s = SEG_DARK;
                dp_nxt_s  = ACTIVE_LOW;
            end
        end else begin
            an_nxt_s  = an_r;
            seg_nxt_s = seg_r;
            dp_nxt_s  = dp_out_r;
        end
    end

    // Output registers driving the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r     <= AN_DARK;
            seg_r    <= SEG_DARK;
            dp_out_r <= ACTIVE_LOW;
        end else begin
            an_r     <= an_nxt_s;
            seg_r    <= seg_nxt_s;
            dp_out_r <= dp_nxt_s;
        end
    end

    assign an        = an_r;
    assign seg       = seg_r;
    assign dp_out    = dp_out_r;
    assign scan_tick = tick_s;

endmodule
